// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select bus of a shared 4:1 mux and
// registers the selected requester's data, with a per-owner hold limit.
module mux_rr_arbiter #(
   parameter int DATA_W   = 8,
   parameter int MAX_HOLD = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [3:0]          req,
   input  logic [4*DATA_W-1:0] data_in,
   output logic [3:0]          grant,
   output logic [1:0]          sel,
   output logic                valid,
   output logic [DATA_W-1:0]   data_out
);

   localparam int HOLD_W = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD);
   localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

   typedef enum logic {
      IDLE,
      GRANT
   } state_t;

   state_t              state_q, state_d;
   logic [3:0]          grant_q, grant_d;
   logic [1:0]          sel_q, sel_d;
   logic                valid_q, valid_d;
   logic [DATA_W-1:0]   data_out_q, data_out_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [1:0]          last_q, last_d;
   logic [1:0]          pick_idle;
   logic [1:0]          pick_release;
   logic                served;

   // Search base+1, base+2, base+3, base; the nearest set request wins.
   function automatic logic [1:0] rr_pick(input logic [1:0] base, input logic [3:0] r);
      logic [1:0] idx;
      rr_pick = base;
      for (int i = 4; i >= 1; i--) begin
         idx = base + 2'(i);
         if (r[idx]) rr_pick = idx;
      end
   endfunction

   always_comb begin
      pick_idle    = rr_pick(last_q, req);
      pick_release = rr_pick(sel_q, req);
      served       = |(grant_q & req);
   end

   always_comb begin
      state_d    = state_q;
      grant_d    = grant_q;
      sel_d      = sel_q;
      hold_cnt_d = hold_cnt_q;
      last_d     = last_q;
      unique case (state_q)
         IDLE: begin
            if (|req) begin
               grant_d    = 4'b0001 << pick_idle;
               sel_d      = pick_idle;
               hold_cnt_d = HOLD_ONE;
               state_d    = GRANT;
            end
         end
         GRANT: begin
            if (req[sel_q] && (hold_cnt_q < HOLD_MAX)) begin
               hold_cnt_d = hold_cnt_q + HOLD_ONE;
            end else begin
               // Release and re-pick on the same edge so owners change without a bubble.
               last_d = sel_q;
               if (|req) begin
                  grant_d    = 4'b0001 << pick_release;
                  sel_d      = pick_release;
                  hold_cnt_d = HOLD_ONE;
               end else begin
                  grant_d    = 4'b0000;
                  hold_cnt_d = '0;
                  state_d    = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      valid_d    = served;
      data_out_d = data_out_q;
      if (served) data_out_d = data_in[int'(sel_q)*DATA_W +: DATA_W];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         grant_q    <= 4'b0000;
         sel_q      <= 2'b00;
         valid_q    <= 1'b0;
         data_out_q <= '0;
         hold_cnt_q <= '0;
         last_q     <= 2'd3;
      end else begin
         state_q    <= state_d;
         grant_q    <= grant_d;
         sel_q      <= sel_d;
         valid_q    <= valid_d;
         data_out_q <= data_out_d;
         hold_cnt_q <= hold_cnt_d;
         last_q     <= last_d;
      end
   end

   assign grant    = grant_q;
   assign sel      = sel_q;
   assign valid    = valid_q;
   assign data_out = data_out_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: one default instance plus a MAX_HOLD=1
// instance sharing the same inputs to exercise per-cycle rotation.
module tb_mux_rr_arbiter;

   logic        clk;
   logic        rst_n;
   logic [3:0]  req;
   logic [31:0] data_in;
   logic [3:0]  grant, grant1;
   logic [1:0]  sel, sel1;
   logic        valid, valid1;
   logic [7:0]  data_out, data_out1;
   logic [7:0]  lanes [4];
   int          checks;
   int          errors;

   mux_rr_arbiter #(.DATA_W(8), .MAX_HOLD(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
      .grant(grant), .sel(sel), .valid(valid), .data_out(data_out)
   );

   mux_rr_arbiter #(.DATA_W(8), .MAX_HOLD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
      .grant(grant1), .sel(sel1), .valid(valid1), .data_out(data_out1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      req   = 4'b0000;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      req   = 4'hF;
      rst_n = 1'b0;
      repeat (3) step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL reset_grant got %b exp 0000", grant); end
      checks++; if (sel !== 2'b00) begin errors++; $display("[TB] FAIL reset_sel got %0d exp 0", sel); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %b exp 0", valid); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data got %h exp 00", data_out); end
      req   = 4'b0000;
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      step();
      checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL single_grant got %b exp 0100", grant); end
      checks++; if (sel !== 2'd2) begin errors++; $display("[TB] FAIL single_sel got %0d exp 2", sel); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL single_valid_early got %b exp 0", valid); end
      step();
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL single_valid got %b exp 1", valid); end
      checks++; if (data_out !== 8'hA5) begin errors++; $display("[TB] FAIL single_data got %h exp a5", data_out); end
      req = 4'b0000;
      step();
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL single_release got %b exp 0000", grant); end
      checks++; if (data_out !== 8'hA5) begin errors++; $display("[TB] FAIL single_data_hold got %h exp a5", data_out); end
   endtask

   task automatic test_contention();
      logic [3:0] exp_g;
      logic [3:0] exp_g1;
      logic [7:0] exp_d;
      do_reset();
      req = 4'hF;
      for (int i = 0; i < 17; i++) begin
         step();
         exp_g  = 4'b0001 << ((i / 4) % 4);
         exp_g1 = 4'b0001 << (i % 4);
         checks++; if (grant !== exp_g) begin errors++; $display("[TB] FAIL contention_grant cycle %0d got %b exp %b", i, grant, exp_g); end
         checks++; if (grant1 !== exp_g1) begin errors++; $display("[TB] FAIL hold1_grant cycle %0d got %b exp %b", i, grant1, exp_g1); end
         if (i > 0) begin
            exp_d = lanes[((i - 1) / 4) % 4];
            checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL contention_valid cycle %0d got %b exp 1", i, valid); end
            checks++; if (data_out !== exp_d) begin errors++; $display("[TB] FAIL contention_data cycle %0d got %h exp %h", i, data_out, exp_d); end
         end
      end
   endtask

   task automatic test_early_release();
      do_reset();
      req = 4'b1001;
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL early_grant0 got %b exp 0001", grant); end
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL early_hold got %b exp 0001", grant); end
      checks++; if (data_out !== 8'h0F) begin errors++; $display("[TB] FAIL early_data0 got %h exp 0f", data_out); end
      req = 4'b1000;
      step();
      checks++; if (grant !== 4'b1000) begin errors++; $display("[TB] FAIL early_switch got %b exp 1000", grant); end
      checks++; if (sel !== 2'd3) begin errors++; $display("[TB] FAIL early_sel got %0d exp 3", sel); end
      step();
      checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL early_valid got %b exp 1", valid); end
      checks++; if (data_out !== 8'h3C) begin errors++; $display("[TB] FAIL early_data3 got %h exp 3c", data_out); end
   endtask

   task automatic test_sole_hog();
      do_reset();
      req = 4'b0010;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++; if (grant !== 4'b0010) begin errors++; $display("[TB] FAIL hog_grant cycle %0d got %b exp 0010", i, grant); end
         if (i > 0) begin
            checks++; if (valid !== 1'b1) begin errors++; $display("[TB] FAIL hog_valid cycle %0d got %b exp 1", i, valid); end
            checks++; if (data_out !== 8'h1E) begin errors++; $display("[TB] FAIL hog_data cycle %0d got %h exp 1e", i, data_out); end
         end
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      req = 4'b0100;
      step();
      step();
      checks++; if (grant !== 4'b0100) begin errors++; $display("[TB] FAIL async_pre_grant got %b exp 0100", grant); end
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (grant !== 4'b0000) begin errors++; $display("[TB] FAIL async_grant got %b exp 0000", grant); end
      checks++; if (sel !== 2'b00) begin errors++; $display("[TB] FAIL async_sel got %0d exp 0", sel); end
      checks++; if (valid !== 1'b0) begin errors++; $display("[TB] FAIL async_valid got %b exp 0", valid); end
      checks++; if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL async_data got %h exp 00", data_out); end
      #1;
      rst_n = 1'b1;
      req   = 4'hF;
      step();
      checks++; if (grant !== 4'b0001) begin errors++; $display("[TB] FAIL async_first_grant got %b exp 0001", grant); end
   endtask

   initial begin
      checks   = 0;
      errors   = 0;
      lanes[0] = 8'h0F;
      lanes[1] = 8'h1E;
      lanes[2] = 8'hA5;
      lanes[3] = 8'h3C;
      data_in  = {8'h3C, 8'hA5, 8'h1E, 8'h0F};
      req      = 4'b0000;
      rst_n    = 1'b1;
      #2;
      test_reset();
      test_single();
      test_contention();
      test_early_release();
      test_sole_hog();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
